// File: rtl/hilo_md_ctrl.sv
// hilo_md_ctrl: multi-cycle MULT/MULTU/DIV/DIVU sequencer and HI/LO owner.
// Radix-2 shift-add multiply and restoring divide, one iteration per cycle.
// Optional macro MD_EARLY_OUT_EN: multiplies finish as soon as the remaining
// multiplier bits are all zero (division timing is unaffected).
module hilo_md_ctrl #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [DATA_W-1:0] src_a,
   input  logic [DATA_W-1:0] src_b,
   input  logic              flush,
   input  logic              mthi_we,
   input  logic              mtlo_we,
   input  logic [DATA_W-1:0] mt_data,
   output logic              stall,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo
);

   typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

   state_t                state, state_nx;
   logic [2*DATA_W-1:0]   acc;
   logic [DATA_W-1:0]     opb;
   logic [CNT_W-1:0]      cnt;
   logic                  is_div;
   logic                  neg_res;
   logic                  neg_rem;
   logic                  load;
   logic                  early;

   logic                  sgn_op;
   logic                  a_neg, b_neg;
   logic [DATA_W-1:0]     abs_a, abs_b;
   logic [DATA_W:0]       mul_sum;
   logic [2*DATA_W-1:0]   mul_step;
   logic [DATA_W:0]       rem_ext;
   logic [DATA_W+1:0]     div_diff;
   logic [2*DATA_W-1:0]   div_step;
   logic [2*DATA_W-1:0]   step;
   logic [2*DATA_W-1:0]   acc_calc;
   logic [2*DATA_W-1:0]   prod_fix;
   logic [DATA_W-1:0]     quot_fix, rem_fix;
   logic [DATA_W-1:0]     res_hi, res_lo;

   // Operand conditioning: signed ops run on magnitudes, signs are fixed up at the end
   always_comb begin
      sgn_op = ~op[0];
      a_neg  = sgn_op & src_a[DATA_W-1];
      b_neg  = sgn_op & src_b[DATA_W-1];
      abs_a  = a_neg ? -src_a : src_a;
      abs_b  = b_neg ? -src_b : src_b;
   end

   // One iteration of the multiplier or divider; the divider keeps the bit
   // shifted out of the remainder so the trial subtract sees all DATA_W+1 bits
   always_comb begin
      mul_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, opb};
      mul_step = acc[0] ? {mul_sum, acc[DATA_W-1:1]} : {1'b0, acc[2*DATA_W-1:1]};
      rem_ext  = acc[2*DATA_W-1:DATA_W-1];
      div_diff = {1'b0, rem_ext} - {2'b00, opb};
      div_step = div_diff[DATA_W+1] ? {acc[2*DATA_W-2:0], 1'b0}
                                    : {div_diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
      step     = is_div ? div_step : mul_step;
   end

`ifdef MD_EARLY_OUT_EN
   logic [CNT_W:0]       cnt_p1;
   logic [DATA_W-1:0]    mask;
   logic [CNT_W-1:0]     shamt;

   // Stop a multiply once no multiplier bits remain, then shift the accumulator
   // by the skipped iterations so the result matches the full-length run
   always_comb begin
      cnt_p1   = {1'b0, cnt} + (CNT_W+1)'(1);
      mask     = {DATA_W{1'b1}} >> cnt_p1;
      shamt    = CNT_W'(DATA_W-1) - cnt;
      early    = ~is_div & ((step[DATA_W-1:0] & mask) == '0);
      acc_calc = early ? (step >> shamt) : step;
   end
`else
   // Fixed-length iteration: every op runs all DATA_W cycles
   always_comb begin
      early    = 1'b0;
      acc_calc = step;
   end
`endif

   // Sign correction of the finished result and the HI/LO values to commit
   always_comb begin
      prod_fix = neg_res ? -acc : acc;
      quot_fix = neg_res ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
      rem_fix  = neg_rem ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];
      res_hi   = is_div ? rem_fix : prod_fix[2*DATA_W-1:DATA_W];
      res_lo   = is_div ? quot_fix : prod_fix[DATA_W-1:0];
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state logic plus stall/done; a flush kills the op and suppresses the commit
   always_comb begin
      state_nx = state;
      stall    = 1'b0;
      done     = 1'b0;
      load     = 1'b0;
      case (state)
         IDLE: begin
            if (start && !flush) begin
               state_nx = CALC;
               load     = 1'b1;
               stall    = 1'b1;
            end
         end
         CALC: begin
            stall = 1'b1;
            if (flush)
               state_nx = IDLE;
            else if (cnt == CNT_W'(DATA_W-1) || early)
               state_nx = FINISH;
         end
         FINISH: begin
            state_nx = IDLE;
            done     = ~flush;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   // Datapath: latch magnitudes and sign flags on issue, iterate while in CALC
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc     <= '0;
         opb     <= '0;
         cnt     <= '0;
         is_div  <= 1'b0;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
      end else if (load) begin
         acc     <= {{DATA_W{1'b0}}, (op[1] ? abs_a : abs_b)};
         opb     <= op[1] ? abs_b : abs_a;
         cnt     <= '0;
         is_div  <= op[1];
         neg_res <= a_neg ^ b_neg;
         neg_rem <= a_neg;
      end else if (state == CALC) begin
         acc <= acc_calc;
         cnt <= cnt + CNT_W'(1);
      end
   end

   // HI/LO: result commit on done, MTHI/MTLO only when idle with no issue
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi <= '0;
         lo <= '0;
      end else if (done) begin
         hi <= res_hi;
         lo <= res_lo;
      end else if (state == IDLE && !start) begin
         if (mthi_we) hi <= mt_data;
         if (mtlo_we) lo <= mt_data;
      end
   end

endmodule

// File: tb/tb_hilo_md_ctrl.sv
// tb_hilo_md_ctrl: table-driven check of hilo_md_ctrl results and timing,
// plus hand-written MTHI/MTLO, flush and mid-operation reset sequences.
module tb_hilo_md_ctrl;

   logic        clk;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] src_a, src_b;
   logic        flush;
   logic        mthi_we, mtlo_we;
   logic [31:0] mt_data;
   logic        stall, busy, done;
   logic [31:0] hi, lo;

   int n_checks;
   int n_fail;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
   } vec_t;

   vec_t vecs[9];

   hilo_md_ctrl #(.DATA_W(32), .CNT_W(5)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .op      (op),
      .src_a   (src_a),
      .src_b   (src_b),
      .flush   (flush),
      .mthi_we (mthi_we),
      .mtlo_we (mtlo_we),
      .mt_data (mt_data),
      .stall   (stall),
      .busy    (busy),
      .done    (done),
      .hi      (hi),
      .lo      (lo)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // The pipeline never strobes MTHI/MTLO alongside an issue or while busy
   always @(posedge clk) begin
      if (!rst && (mthi_we || mtlo_we) && (start || busy)) begin
         $display("[TB] FAIL mt_strobe_misuse: start=%0b busy=%0b", start, busy);
         n_fail++;
      end
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Issue one op in the current cycle (called just after a falling edge) and
   // watch 40 cycles, recording when done fires and how long stall was high
   task automatic apply_stimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output int done_cyc, output int done_cnt,
                                 output int stall_cnt, output logic stall_at_done);
      done_cyc      = -1;
      done_cnt      = 0;
      stall_cnt     = 0;
      stall_at_done = 1'b1;
      start = 1'b1;
      op    = o;
      src_a = a;
      src_b = b;
      #1;
      for (int c = 0; c < 40; c++) begin
         if (c > 0) begin
            @(negedge clk);
            start = 1'b0;
            #1;
         end
         if (stall) stall_cnt++;
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) begin
               done_cyc      = c;
               stall_at_done = stall;
            end
         end
      end
   endtask

   initial begin
      int   dc, dn, sc;
      logic sd;
      n_checks = 0;
      n_fail   = 0;

      vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33};
      vecs[1] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 33};
      vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
      vecs[3] = '{2'b11, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, 33};
      vecs[4] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33};
      vecs[5] = '{2'b11, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 33};
      vecs[6] = '{2'b00, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 33};
      vecs[7] = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33};
      vecs[8] = '{2'b01, 32'h0000_0003, 32'h0000_0002, 32'h0000_0000, 32'h0000_0006, 33};
`ifdef MD_EARLY_OUT_EN
      vecs[1].cyc = 4;
      vecs[6].cyc = 32;
      vecs[8].cyc = 3;
`endif

      rst     = 1'b1;
      start   = 1'b0;
      op      = 2'b00;
      src_a   = '0;
      src_b   = '0;
      flush   = 1'b0;
      mthi_we = 1'b0;
      mtlo_we = 1'b0;
      mt_data = '0;

      // Reset state
      #12;
      check_output("reset_hi", hi, 32'h0);
      check_output("reset_lo", lo, 32'h0);
      check_output("reset_busy", {31'b0, busy}, 32'h0);
      check_output("reset_stall", {31'b0, stall}, 32'h0);
      check_output("reset_done", {31'b0, done}, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // Result and timing vectors
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b, dc, dn, sc, sd);
         $display("[TB] vector %0d op=%0d a=0x%08h b=0x%08h -> hi=0x%08h lo=0x%08h done@%0d",
                  i, vecs[i].op, vecs[i].a, vecs[i].b, hi, lo, dc);
         check_output($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
         check_output($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
         check_output($sformatf("vec%0d_done_cycle", i), dc, vecs[i].cyc);
         check_output($sformatf("vec%0d_done_pulses", i), dn, 32'd1);
         check_output($sformatf("vec%0d_stall_cycles", i), sc, vecs[i].cyc);
         check_output($sformatf("vec%0d_stall_at_done", i), {31'b0, sd}, 32'h0);
      end

      // start together with flush in IDLE is ignored
      @(negedge clk);
      start = 1'b1;
      flush = 1'b1;
      op    = 2'b11;
      src_a = 32'd9;
      src_b = 32'd3;
      #1;
      check_output("start_flush_stall", {31'b0, stall}, 32'h0);
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      #1;
      check_output("start_flush_busy", {31'b0, busy}, 32'h0);
      check_output("start_flush_lo", lo, 32'h6);

      // MTHI and MTLO together, then separately
      @(negedge clk);
      mthi_we = 1'b1;
      mtlo_we = 1'b1;
      mt_data = 32'h0000_ABCD;
      @(negedge clk);
      mthi_we = 1'b0;
      mtlo_we = 1'b0;
      #1;
      check_output("mt_both_hi", hi, 32'h0000_ABCD);
      check_output("mt_both_lo", lo, 32'h0000_ABCD);
      @(negedge clk);
      mthi_we = 1'b1;
      mt_data = 32'h0000_1234;
      @(negedge clk);
      mthi_we = 1'b0;
      mtlo_we = 1'b1;
      mt_data = 32'h0000_5678;
      @(negedge clk);
      mtlo_we = 1'b0;
      #1;
      check_output("mthi_hi", hi, 32'h0000_1234);
      check_output("mtlo_lo", lo, 32'h0000_5678);

      // Flush a divide in cycle 10, then issue a new op in cycle 11
      @(negedge clk);
      start = 1'b1;
      op    = 2'b10;
      src_a = 32'hFFFF_FFF9;
      src_b = 32'h0000_0002;
      dn    = 0;
      #1;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (c == 10) flush = 1'b1;
         #1;
         if (done) dn++;
      end
      @(negedge clk);
      flush = 1'b0;
      #1;
      if (done) dn++;
      check_output("flush_busy", {31'b0, busy}, 32'h0);
      check_output("flush_stall", {31'b0, stall}, 32'h0);
      check_output("flush_hi", hi, 32'h0000_1234);
      check_output("flush_lo", lo, 32'h0000_5678);
      check_output("flush_no_done", dn, 32'd0);
      apply_stimulus(2'b11, 32'd100, 32'd7, dc, dn, sc, sd);
      check_output("after_flush_hi", hi, 32'h2);
      check_output("after_flush_lo", lo, 32'hE);
      check_output("after_flush_done_cycle", dc, 32'd33);

      // Asynchronous reset in cycle 15 of a multu
      @(negedge clk);
      start = 1'b1;
      op    = 2'b01;
      src_a = 32'hFFFF_FFFF;
      src_b = 32'hFFFF_FFFF;
      for (int c = 1; c <= 15; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst = 1'b1;
      #1;
      check_output("midreset_hi", hi, 32'h0);
      check_output("midreset_lo", lo, 32'h0);
      check_output("midreset_stall", {31'b0, stall}, 32'h0);
      check_output("midreset_busy", {31'b0, busy}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      apply_stimulus(2'b00, 32'h0001_0000, 32'h0001_0000, dc, dn, sc, sd);
      check_output("after_reset_hi", hi, 32'h1);
      check_output("after_reset_lo", lo, 32'h0);
      check_output("after_reset_done_pulses", dn, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
